round_key_sched: RTL
====================

Name: round_key_sched

Overview:
- Sequential AES-128 round-key generator feeding the round datapath's key_i, one key per handshake.
- Encryption: emits round keys 0..10 in forward order.
- Decryption: first expands the cipher key forward to round key 10, then walks the schedule backwards using the inverse key-expansion step, emitting keys 10..0.
- Stores only one 128-bit key; no 11-entry key RAM.

Parameters:
- NR, 10, number of rounds. Only 10 is supported; any other value is a elaboration error.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- start_i  input  1  start request; accepted only when busy_o=0
- enc_or_dec_i  input  1  1=encrypt (forward order), 0=decrypt (reverse order); sampled with start_i
- key_i  input  128  cipher key in round-datapath state layout: [127:96]=row0={k0,k4,k8,k12} ... [31:0]=row3={k3,k7,k11,k15}
- rk_ready_i  input  1  consumer accepts rk_o this cycle
- rk_valid_o  output  1  rk_o/rk_idx_o valid
- rk_o  output  128  round key, same row-major layout as key_i
- rk_idx_o  output  4  round number of rk_o (0..10)
- last_o  output  1  rk_o is the final key of the sequence (idx 10 enc, idx 0 dec)
- busy_o  output  1  sequence in progress
- done_o  output  1  one-cycle pulse after the last key handshake

Behaviour:
- Reset: all outputs 0; FSM=IDLE; key register 0; round counter 0.
- States: IDLE, EXPAND, EMIT.
- IDLE, start_i=1 at edge t:
  - key_i is loaded into the key register; mode latched; busy_o=1 after edge t.
  - Encrypt: next state EMIT, idx=0. rk_valid_o=1 in the cycle after edge t, rk_o=key_i.
  - Decrypt: next state EXPAND, counter=0.
- EXPAND (decrypt only):
  - Each cycle the key register is replaced by the forward step with Rcon[counter+1]; counter increments.
  - After 10 steps, at edge t+10, go to EMIT with idx=10. rk_valid_o rises in the cycle after edge t+10.
  - rk_valid_o=0 throughout EXPAND.
- Forward step:
  - Transpose to words w0..w3.
  - t = SubWord(RotWord(w3)) ^ {Rcon,00,00,00}.
  - w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
- Inverse step, round r key to round r-1 key:
  - w3'=w3^w2; w2'=w2^w1; w1'=w1^w0.
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {Rcon[r],00,00,00}.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- SubWord always uses the forward S-box, in both modes.
- EMIT:
  - rk_o, rk_idx_o and last_o are held stable while rk_valid_o=1 and rk_ready_i=0.
  - On handshake (valid & ready), non-last: the key register takes the next key (forward step with Rcon[idx+1] in enc; inverse step with Rcon[idx] in dec). idx moves ±1. The new key is valid in the next cycle, so throughput is 1 key/cycle under continuous ready.
  - On handshake with last_o=1: go to IDLE. rk_valid_o, busy_o and last_o drop at that edge; done_o=1 for exactly the following cycle.
- start_i while busy_o=1 is ignored: no restart, no queuing.
- start_i asserted in the done_o cycle is accepted, since FSM is IDLE.
- rst_i asserted in any state: IDLE and all outputs 0 at that edge; an in-flight sequence is discarded.
- enc_or_dec_i and key_i are don't-care except in the start cycle.
- rk_o is 0 whenever rk_valid_o=0.

Decomposition:
- Shared package aes_pkg:
  - NR=10
  - Rcon table constant (index 1..10)
  - FSM state encoding
  - row-major <-> word-major transpose functions, reusable by other blocks
- Sub-module key_step (combinational):
  - Inputs: key, rcon, dir.
  - Output: the forward or inverse next key.
  - Instantiates the existing sub_word with enc_or_dec_i tied to 1.
  - The top keeps only the FSM, counter and key register.

Test Plan:
- Encrypt, FIPS-197 key 2b28ab09_7eaef7cf_15d2154f_16a6883c, rk_ready_i=1 → 11 consecutive valid cycles starting the cycle after start.
  - idx0 = key_i.
  - idx1 = a088232a_fa54a36c_fe2c3976_17b13905.
  - idx10 = d0c9e1b6_14ee3f63_f9250c0c_a889c8a6 with last_o=1.
  - done_o pulses the next cycle.
- Decrypt, same key, ready=1 → rk_valid_o=0 for 10 cycles after start.
  - First key idx10 = d0c9e1b6_14ee3f63_f9250c0c_a889c8a6.
  - idx1 = a088232a_fa54a36c_fe2c3976_17b13905.
  - idx0 = 2b28ab09_7eaef7cf_15d2154f_16a6883c with last_o=1.
- Backpressure: random rk_ready_i gaps, both modes → rk_o/rk_idx_o stable during stall; no key skipped or duplicated; sequence identical to the ready=1 runs.
- start_i pulsed during EXPAND and during EMIT → ignored, sequence unchanged; start in the done_o cycle → new sequence begins.
- rst_i asserted mid-EMIT (enc, idx=5) → next cycle all outputs 0, busy_o=0; a fresh start then yields idx0 correctly.
- All-zero key decrypt → first key idx10 is b4ef5bcb3e92e21123e951cf6f8f188e in FIPS word order, transposed to row-major; final key idx0 = 0.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, key-scheduler FSM encoding and state transposes
package aes_pkg;

    localparam int NR = 10;

    // Indexed by round number; entry 0 and 11..15 are never used for a real step.
    localparam logic [7:0] RCON [0:15] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_EMIT
    } state_t;

    // Row-major {row0..row3} <-> word-major {w0..w3}; the mapping is its own inverse.
    function automatic logic [127:0] transpose(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                y[127-32*c-8*r -: 8] = x[127-32*r-8*c -: 8];
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] rows_to_words(input logic [127:0] x);
        return transpose(x);
    endfunction

    function automatic logic [127:0] words_to_rows(input logic [127:0] x);
        return transpose(x);
    endfunction

endpackage

// File: rtl/round_key_sched_key_step.sv
// rtl/round_key_sched_key_step.sv - one forward or inverse AES-128 key-expansion step
module key_step
    import aes_pkg::*;
(
    input  logic [127:0] key,
    input  logic [7:0]   rcon,
    input  logic         dir,
    output logic [127:0] key_next
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] rot_in, sub, t;

    assign {w0, w1, w2, w3} = rows_to_words(key);

    // The inverse step needs SubWord of the recovered w3', which is w3 ^ w2.
    assign rot_in = dir ? w3 : (w3 ^ w2);

    sub_word u_sub_word (
        .word         ({rot_in[23:0], rot_in[31:24]}),
        .enc_or_dec_i (1'b1),
        .result       (sub)
    );

    assign t = sub ^ {rcon, 24'h000000};

    always_comb begin
        n0 = w0;
        n1 = w1;
        n2 = w2;
        n3 = w3;
        if (dir) begin
            n0 = w0 ^ t;
            n1 = w1 ^ n0;
            n2 = w2 ^ n1;
            n3 = w3 ^ n2;
        end else begin
            n3 = w3 ^ w2;
            n2 = w2 ^ w1;
            n1 = w1 ^ w0;
            n0 = w0 ^ t;
        end
    end

    assign key_next = words_to_rows({n0, n1, n2, n3});

endmodule

// File: rtl/sub_word.sv
// rtl/sub_word.sv - byte-wise AES S-box (forward or inverse) over a 32-bit word
module sub_word (
    input  logic [31:0] word,
    input  logic        enc_or_dec_i,
    output logic [31:0] result
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] s;
        r = 8'h01;
        s = x;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        logic [7:0] i;
        i = gf_inv(b);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] b);
        return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
    endfunction

    always_comb begin
        result = '0;
        for (int i = 0; i < 4; i++) begin
            result[8*i +: 8] = enc_or_dec_i ? sbox_fwd(word[8*i +: 8]) : sbox_inv(word[8*i +: 8]);
        end
    end

endmodule

// File: rtl/round_key_sched.sv
// rtl/round_key_sched.sv - sequential AES-128 round-key generator, forward or reverse order
module round_key_sched
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         enc_or_dec_i,
    input  logic [127:0] key_i,
    input  logic         rk_ready_i,
    output logic         rk_valid_o,
    output logic [127:0] rk_o,
    output logic [3:0]   rk_idx_o,
    output logic         last_o,
    output logic         busy_o,
    output logic         done_o
);

    if (NR != aes_pkg::NR) begin : g_nr_check
        $error("round_key_sched supports only NR = 10");
    end

    localparam logic [3:0] LAST_IDX = 4'(NR);

    state_t       state;
    logic [127:0] key_q;
    logic [127:0] step_key;
    logic [3:0]   idx;
    logic         enc_q, valid_q, last_q, busy_q, done_q;
    logic         step_fwd;
    logic [3:0]   rcon_sel;

    // The pre-expansion for decryption always runs forward, whatever the mode.
    assign step_fwd = (state == ST_EXPAND) || enc_q;
    assign rcon_sel = step_fwd ? idx + 4'd1 : idx;

    key_step u_key_step (
        .key      (key_q),
        .rcon     (RCON[rcon_sel]),
        .dir      (step_fwd),
        .key_next (step_key)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            key_q   <= '0;
            idx     <= '0;
            enc_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        key_q  <= key_i;
                        enc_q  <= enc_or_dec_i;
                        busy_q <= 1'b1;
                        idx    <= '0;
                        if (enc_or_dec_i) begin
                            state   <= ST_EMIT;
                            valid_q <= 1'b1;
                            last_q  <= 1'b0;
                        end else begin
                            state <= ST_EXPAND;
                        end
                    end
                end
                ST_EXPAND: begin
                    key_q <= step_key;
                    idx   <= idx + 4'd1;
                    if (idx == LAST_IDX - 4'd1) begin
                        state   <= ST_EMIT;
                        idx     <= LAST_IDX;
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                    end
                end
                ST_EMIT: begin
                    if (valid_q && rk_ready_i) begin
                        if (last_q) begin
                            state   <= ST_IDLE;
                            key_q   <= '0;
                            idx     <= '0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (enc_q) begin
                            key_q  <= step_key;
                            idx    <= idx + 4'd1;
                            last_q <= (idx == LAST_IDX - 4'd1);
                        end else begin
                            key_q  <= step_key;
                            idx    <= idx - 4'd1;
                            last_q <= (idx == 4'd1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rk_valid_o = valid_q;
    assign rk_o       = valid_q ? key_q : '0;
    assign rk_idx_o   = valid_q ? idx : '0;
    assign last_o     = last_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule
